irq_pending_dispatch: RTL and testbench
=======================================

Name: irq_pending_dispatch

Overview:
- Collects per-line interrupt/request pulses into a sticky pending register and masks them with an enable vector.
- Drives the masked vector into the MSB-priority encoder, takes back the encoder's index/valid, and dispatches one winner at a time to the core over a req/ack handshake.
- Sits around the priority encoder as both its upstream source and its downstream consumer, between peripheral interrupt lines and the core's trap logic.

Parameters:
- WIDTH, 8, number of request lines; power of two, >= 2; must match the encoder's WIDTH.
- ID_W is derived, not a parameter: ID_W = ceil(log2(WIDTH)), computed with the same log2 function the encoder uses.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_in  input  WIDTH  request lines; a 1 in any sampled cycle sets the matching pending bit.
- irq_enable  input  WIDTH  per-line mask; 1 = line eligible for dispatch.
- pending_out  output  WIDTH  pending & irq_enable; connects to the encoder's decode input.
- enc_id  input  ID_W  encoder's encode output.
- enc_valid  input  1  encoder's valid output.
- int_req  output  1  dispatch request to core.
- int_id  output  ID_W  line index being dispatched; stable while int_req = 1.
- int_ack  input  1  core accepts the request.
- int_done  input  1  core finished servicing; one-cycle pulse.
- busy  output  1  1 when state != IDLE.
- pending_raw  output  WIDTH  unmasked pending register, for debug/CSR read.

Behaviour:
- Reset (asynchronous, immediate): pending = 0, state = IDLE, int_req = 0, int_id = 0, busy = 0; pending_out = 0.
  - Reset mid-handshake abandons the dispatch. No ack or done is expected afterwards.
- Pending register, per bit i, each edge: pending[i] <= irq_in[i] | (pending[i] & ~clr[i]).
  - clr[i] = 1 only on the REQ->SERVICE transition when int_id == i.
  - Simultaneous set and clear of the same bit: set wins, bit stays 1.
- pending_out is combinational from the register and irq_enable. The encoder is combinational, so enc_id/enc_valid are valid in the same cycle.
- FSM, 3 states, registered:
  - IDLE: int_req = 0. If enc_valid, then int_id <= enc_id, int_req <= 1, go to REQ. Otherwise stay.
  - REQ: int_req = 1 and int_id held. enc_id changes are ignored, even if a higher line arrives or the line is disabled; there is no retraction.
    - On int_ack: int_req <= 0, clear pending[int_id] per the rule above, go to SERVICE.
  - SERVICE: int_req = 0, int_id held. On int_done, go to IDLE.
    - New requests accumulate in pending but are not dispatched until IDLE.
- int_ack outside REQ and int_done outside SERVICE are ignored.
- int_ack and int_done asserted together in REQ: only the ack is taken; the bench must pulse done later.
- Latency, zero-based edges:
  - irq_in high before edge N: pending set at edge N, int_req = 1 after edge N+1.
  - int_done at edge M: IDLE after M. If something is pending, int_req = 1 again after edge M+1.
  - No back-to-back dispatch faster than ack -> SERVICE -> done -> IDLE -> REQ.
- Priority is MSB-first, fixed by the encoder. This block adds no fairness.
- irq_enable = 0 on a pending line keeps the bit pending (pending_raw = 1, pending_out = 0). Re-enabling makes it eligible in the same cycle.
- All outputs are registered except pending_out, which is combinational.

Test Plan:
- Reset then irq_in = 8'b0000_0100 for 1 cycle, enable = 8'hFF -> pending_raw = 8'h04 next edge; int_req = 1 with int_id = 2 one edge later; int_ack -> pending_raw = 8'h00, busy stays 1 until int_done.
- irq_in = 8'h81 in one cycle -> first dispatch int_id = 7; after ack + done, second dispatch int_id = 0; pending_raw finally 8'h00.
- While in REQ with int_id = 3, raise irq_in[6] -> int_id stays 3 until ack; after done, int_id = 6 dispatched.
- Ack cycle with irq_in[int_id] = 1 again -> pending bit remains 1; line re-dispatched after done.
- enable = 8'h0F with irq_in = 8'h30 -> no int_req, pending_raw = 8'h30; set enable = 8'hFF -> int_req with int_id = 5.
- Assert reset while int_req = 1 -> int_req, int_id, busy and pending_raw go to 0 immediately, asynchronously to clock; later int_done pulses are ignored.

Source files
------------

// File: rtl/irq_pending_dispatch.sv
// irq_pending_dispatch: sticky pending register masked into an external MSB-priority encoder,
// dispatching one winner at a time to the core over a req/ack/done handshake.
module irq_pending_dispatch #(
  parameter int WIDTH = 8,
  localparam int ID_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] irq_in,
  input  logic [WIDTH-1:0] irq_enable,
  output logic [WIDTH-1:0] pending_out,
  input  logic [ID_W-1:0]  enc_id,
  input  logic             enc_valid,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             busy,
  output logic [WIDTH-1:0] pending_raw
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_clr;
  logic [ID_W-1:0]  r_id;
  assign w_clr = (r_state == REQ && int_ack) ? WIDTH'(1) << r_id : '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // a new request in the accept cycle re-arms the bit because set wins over clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_id      <= '0;
    end else begin
      r_pending <= irq_in | (r_pending & ~w_clr);
      if (r_state == IDLE && enc_valid) r_id <= enc_id;
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && enc_valid) w_next = REQ;
    else if (r_state == REQ && int_ack) w_next = SERVICE;
    else if (r_state == SERVICE && int_done) w_next = IDLE;
  end
  always_comb begin
    int_req     = r_state == REQ;
    busy        = r_state != IDLE;
    int_id      = r_id;
    pending_raw = r_pending;
    pending_out = r_pending & irq_enable;
  end
endmodule

// File: tb/tb_irq_pending_dispatch.sv
// tb_irq_pending_dispatch: scoreboard bench with a behavioural MSB-first encoder closing the loop.
module tb_irq_pending_dispatch;
  logic       clock = 0;
  logic       reset = 1;
  logic [7:0] irq_in = 0;
  logic [7:0] irq_enable = 8'hFF;
  logic [7:0] pending_out;
  logic [2:0] enc_id;
  logic       enc_valid;
  logic       int_req;
  logic [2:0] int_id;
  logic       int_ack = 0;
  logic       int_done = 0;
  logic       busy;
  logic [7:0] pending_raw;
  int         n_checks = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];

  irq_pending_dispatch #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .irq_enable(irq_enable),
    .pending_out(pending_out), .enc_id(enc_id), .enc_valid(enc_valid),
    .int_req(int_req), .int_id(int_id), .int_ack(int_ack), .int_done(int_done),
    .busy(busy), .pending_raw(pending_raw)
  );

  always #5 clock = ~clock;

  always_comb begin
    enc_valid = |pending_out;
    enc_id = '0;
    for (int i = 0; i < 8; i++) if (pending_out[i]) enc_id = i[2:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq_in = v;
    step();
    irq_in = 0;
  endtask

  task automatic wait_req();
    logic [2:0] e;
    for (int k = 0; k < 20 && !int_req; k++) step();
    chk("req_seen", int_req, 1);
    if (exp_q.size() == 0) begin
      chk("queue_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk("int_id", int_id, e);
    end
  endtask

  task automatic ack_done(input logic [7:0] irq_during, input logic [7:0] exp_pend);
    int_ack = 1;
    irq_in = irq_during;
    step();
    int_ack = 0;
    irq_in = 0;
    chk("pend_after_ack", pending_raw, exp_pend);
    chk("req_drop", int_req, 0);
    chk("busy_service", busy, 1);
    step();
    chk("busy_hold", busy, 1);
    int_done = 1;
    step();
    int_done = 0;
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    #1;
    chk("rst_req", int_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pending_raw, 0);
    chk("rst_pout", pending_out, 0);
    step();
    reset = 0;
    step();
    // single line
    pulse_irq(8'h04);
    chk("pend_set", pending_raw, 8'h04);
    chk("req_not_yet", int_req, 0);
    exp_q.push_back(3'd2);
    wait_req();
    ack_done(8'h00, 8'h00);
    // two lines at once, MSB first
    pulse_irq(8'h81);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    wait_req();
    ack_done(8'h00, 8'h01);
    wait_req();
    ack_done(8'h00, 8'h00);
    // higher line arriving during REQ does not pre-empt
    pulse_irq(8'h08);
    exp_q.push_back(3'd3);
    wait_req();
    pulse_irq(8'h40);
    step();
    chk("hold_id", int_id, 3);
    chk("hold_req", int_req, 1);
    exp_q.push_back(3'd6);
    ack_done(8'h00, 8'h40);
    wait_req();
    ack_done(8'h00, 8'h00);
    // set wins over clear in the ack cycle
    pulse_irq(8'h02);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    wait_req();
    ack_done(8'h02, 8'h02);
    wait_req();
    ack_done(8'h00, 8'h00);
    // ack and done together: only the ack is taken
    pulse_irq(8'h10);
    exp_q.push_back(3'd4);
    wait_req();
    int_ack = 1;
    int_done = 1;
    step();
    int_ack = 0;
    int_done = 0;
    chk("ackdone_busy", busy, 1);
    step();
    chk("ackdone_hold", busy, 1);
    int_done = 1;
    step();
    int_done = 0;
    chk("ackdone_idle", busy, 0);
    // masked lines stay pending, re-enable is immediate
    irq_enable = 8'h0F;
    pulse_irq(8'h30);
    step();
    step();
    chk("mask_noreq", int_req, 0);
    chk("mask_raw", pending_raw, 8'h30);
    chk("mask_pout", pending_out, 8'h00);
    irq_enable = 8'hFF;
    #1;
    chk("unmask_pout", pending_out, 8'h30);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd4);
    wait_req();
    ack_done(8'h00, 8'h10);
    wait_req();
    ack_done(8'h00, 8'h00);
    // asynchronous reset mid-handshake
    pulse_irq(8'h81);
    exp_q.push_back(3'd7);
    wait_req();
    #3;
    reset = 1;
    #1;
    chk("arst_req", int_req, 0);
    chk("arst_id", int_id, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pend", pending_raw, 0);
    step();
    reset = 0;
    int_done = 1;
    step();
    int_done = 0;
    step();
    chk("post_rst_req", int_req, 0);
    chk("post_rst_busy", busy, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
